// File: rtl/hicore_icb_arb2_if.sv
// ICB link bundle: one command channel and one response channel.
// The master modport drives commands; the slave modport drives responses.
interface hicore_icb_arb2_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_read;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/hicore_icb_arb2.sv
// Two-master to one-slave ICB arbiter: round-robin command grant, combinational forwarding,
// and an in-order owner-ID FIFO that steers each slave response back to its master.
module hicore_icb_arb2 #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned OSTD_DEPTH = 2,
  parameter int unsigned OSTD_LOG2  = 1
) (
  input  logic              clk,
  input  logic              rst,
  hicore_icb_arb2_if.slave  m0,
  hicore_icb_arb2_if.slave  m1,
  hicore_icb_arb2_if.master s
);

  localparam logic [OSTD_LOG2-1:0] PtrOne  = OSTD_LOG2'(1);
  localparam logic [OSTD_LOG2:0]   CntOne  = (OSTD_LOG2 + 1)'(1);
  localparam logic [OSTD_LOG2:0]   CntFull = (OSTD_LOG2 + 1)'(OSTD_DEPTH);

  logic                 prio_q, prio_d;
  logic                 fifo_q [OSTD_DEPTH];
  logic                 fifo_d [OSTD_DEPTH];
  logic [OSTD_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [OSTD_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [OSTD_LOG2:0]   cnt_q, cnt_d;

  logic gnt0, gnt1, gnt_any;
  logic full, empty;
  logic cmd_hsk, rsp_hsk;
  logic head;

  // A lone requester always wins; prio only breaks ties.
  assign gnt0    = m0.cmd_valid & (~m1.cmd_valid | ~prio_q);
  assign gnt1    = m1.cmd_valid & (~m0.cmd_valid |  prio_q);
  assign gnt_any = gnt0 | gnt1;

  assign full  = (cnt_q == CntFull);
  assign empty = (cnt_q == '0);

  assign s.cmd_valid = gnt_any & ~full;
  assign s.cmd_read  = gnt1 ? m1.cmd_read  : m0.cmd_read;
  assign s.cmd_addr  = gnt1 ? m1.cmd_addr  : m0.cmd_addr;
  assign s.cmd_wdata = gnt1 ? m1.cmd_wdata : m0.cmd_wdata;
  assign s.cmd_wmask = gnt1 ? m1.cmd_wmask : m0.cmd_wmask;

  // Full blocks commands even when a pop happens this cycle, keeping rsp->cmd paths apart.
  assign m0.cmd_ready = gnt0 & ~full & s.cmd_ready;
  assign m1.cmd_ready = gnt1 & ~full & s.cmd_ready;

  assign cmd_hsk = s.cmd_valid & s.cmd_ready;

  assign head = fifo_q[rd_ptr_q];

  assign m0.rsp_rdata = s.rsp_rdata;
  assign m1.rsp_rdata = s.rsp_rdata;
  assign m0.rsp_err   = s.rsp_err;
  assign m1.rsp_err   = s.rsp_err;

  always_comb begin
    m0.rsp_valid = 1'b0;
    m1.rsp_valid = 1'b0;
    s.rsp_ready  = 1'b1;
    if (!empty) begin
      m0.rsp_valid = s.rsp_valid & ~head;
      m1.rsp_valid = s.rsp_valid &  head;
      s.rsp_ready  = head ? m1.rsp_ready : m0.rsp_ready;
    end
  end

  // Responses with nothing outstanding are accepted and dropped.
  assign rsp_hsk = s.rsp_valid & s.rsp_ready & ~empty;

  always_comb begin
    prio_d   = prio_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (cmd_hsk) begin
      fifo_d[wr_ptr_q] = gnt1;
      wr_ptr_d         = wr_ptr_q + PtrOne;
      prio_d           = ~gnt1;
    end
    if (rsp_hsk) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({cmd_hsk, rsp_hsk})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q   <= 1'b0;
      fifo_q   <= '{default: 1'b0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      prio_q   <= prio_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  cnt_bound_a: assert property (@(posedge clk) disable iff (rst) cnt_q <= CntFull);
  one_ready_a: assert property (@(posedge clk) disable iff (rst)
                                !(m0.cmd_ready && m1.cmd_ready));

endmodule
